// File: rtl/bnn_conv_multi_kernel.sv
// Binary 3x3 convolution engine. It streams square binary images (one row per
// word) from SRAM and applies NUM_KERNELS XNOR-popcount kernels in parallel.
// It writes one output row word per kernel back to SRAM, and keeps processing
// images until it reads the sentinel header.
// Optional feature macro: BNN_THRESH_PROG_EN selects a per-kernel threshold
// from weight bits [12:9]. When the macro is undefined the threshold is 5.
module bnn_conv_multi_kernel #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int NUM_KERNELS = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              dut_err,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  localparam int WW   = $clog2(DATA_W) + 1;
  localparam int KI_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
`ifdef BNN_THRESH_PROG_EN
  localparam int WBITS = 13;
`else
  localparam int WBITS = 9;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_W, HDR, FILL, EMIT, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [KI_W-1:0]   kidx_q, kidx_d;
  logic [WW-1:0]     row_cnt_q, row_cnt_d;
  logic [WW-1:0]     w_q, w_d;
  logic [DATA_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [WBITS-1:0]  kern_q [NUM_KERNELS];
  logic [WBITS-1:0]  kern_d [NUM_KERNELS];

  logic [WW-1:0]     hdr_w;
  logic              hdr_sentinel, hdr_bad, last_k, row_last;
  logic [DATA_W-1:0] conv_word [NUM_KERNELS];
  logic [DATA_W-1:0] sel_word;
  logic [8:0]        win;
  int                match_cnt, thresh;

  if (DATA_W > WBITS) begin : g_unused
    logic unused_wmem_bits;
    assign unused_wmem_bits = ^wmem_dut_read_data[DATA_W-1:WBITS];
  end

  // Header decode and loop-end conditions shared by the control and datapath logic
  always_comb begin
    hdr_w        = sram_dut_read_data[WW-1:0];
    hdr_sentinel = (sram_dut_read_data[7:0] == 8'hFF);
    hdr_bad      = (hdr_w < WW'(3)) || (hdr_w > WW'(DATA_W));
    last_k       = (kidx_q == KI_W'(NUM_KERNELS - 1));
    row_last     = ((row_cnt_q + WW'(1)) == (w_q - WW'(2)));
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; reads wait until the data bus reflects the current address
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (dut_run) state_d = LOAD_W;
      LOAD_W: if (cnt_q == 4'(NUM_KERNELS)) state_d = HDR;
      HDR:    if (rd_valid_q) state_d = (hdr_sentinel || hdr_bad) ? DONE : FILL;
      FILL:   if (rd_valid_q && cnt_q == 4'd2) state_d = EMIT;
      EMIT:   if (last_k) state_d = row_last ? HDR : SHIFT;
      SHIFT:  if (rd_valid_q) state_d = EMIT;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: addresses, counters, weight capture and the row window
  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    kidx_d    = kidx_q;
    row_cnt_d = row_cnt_q;
    w_d       = w_q;
    top_d     = top_q;
    mid_d     = mid_q;
    bot_d     = bot_q;
    kern_d    = kern_q;
    case (state_q)
      IDLE: begin
        if (dut_run) begin
          rd_addr_d = '0;
          wr_addr_d = '0;
          err_d     = 1'b0;
          cnt_d     = '0;
        end
      end
      LOAD_W: begin
        cnt_d = cnt_q + 4'd1;
        for (int k = 0; k < NUM_KERNELS; k++)
          if (cnt_q == 4'(k + 1)) kern_d[k] = wmem_dut_read_data[WBITS-1:0];
      end
      HDR: begin
        if (rd_valid_q && !hdr_sentinel) begin
          if (hdr_bad) begin
            err_d = 1'b1;
          end else begin
            w_d       = hdr_w;
            row_cnt_d = '0;
            cnt_d     = '0;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      FILL, SHIFT: begin
        if (rd_valid_q) begin
          top_d     = mid_q;
          mid_d     = bot_q;
          bot_d     = sram_dut_read_data;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          cnt_d     = cnt_q + 4'd1;
          kidx_d    = '0;
        end
      end
      EMIT: begin
        if (wr_addr_q != '1) wr_addr_d = wr_addr_q + ADDR_W'(1);
        kidx_d = kidx_q + KI_W'(1);
        if (last_k) begin
          kidx_d    = '0;
          row_cnt_d = row_cnt_q + WW'(1);
        end
      end
      default: ;
    endcase
    rd_valid_d = (rd_addr_d == rd_addr_q);
  end

  // Datapath registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      kidx_q     <= '0;
      row_cnt_q  <= '0;
      w_q        <= '0;
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      for (int k = 0; k < NUM_KERNELS; k++) kern_q[k] <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      kidx_q     <= kidx_d;
      row_cnt_q  <= row_cnt_d;
      w_q        <= w_d;
      top_q      <= top_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      kern_q     <= kern_d;
    end
  end

  // XNOR-popcount over every 3x3 window of the current three rows, for each kernel
  always_comb begin
    win       = '0;
    match_cnt = 0;
    thresh    = 5;
    for (int k = 0; k < NUM_KERNELS; k++) begin
`ifdef BNN_THRESH_PROG_EN
      thresh = int'(kern_q[k][12:9]);
`else
      thresh = 5;
`endif
      conv_word[k] = '0;
      for (int j = 0; j <= DATA_W - 3; j++) begin
        win       = {bot_q[j +: 3], mid_q[j +: 3], top_q[j +: 3]};
        match_cnt = $countones(~(win ^ kern_q[k][8:0]));
        if ((j + 2 < int'(w_q)) && (match_cnt >= thresh)) conv_word[k][j] = 1'b1;
      end
    end
  end

  // Output decode from the current state and registers
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_KERNELS; k++)
      if (KI_W'(k) == kidx_q) sel_word = conv_word[k];
    dut_busy               = (state_q != IDLE) && (state_q != DONE);
    dut_err                = err_q;
    dut_sram_read_address  = rd_addr_q;
    dut_sram_write_address = wr_addr_q;
    dut_sram_write_enable  = (state_q == EMIT);
    dut_sram_write_data    = (state_q == EMIT) ? sel_word : '0;
    dut_wmem_read_address  = (state_q == LOAD_W) ? ADDR_W'(cnt_q) : '0;
  end

endmodule
